// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and the per-slot update priority used by the pipeline register chain.
package pipe_stage_chain_pkg;

    localparam int DEF_STAGES = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_NSRC   = 2;
    localparam int DEF_CNT_W  = 16;

    // Register address that never forwards (hard-wired zero register)
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_ADVANCE
    } slot_act_e;

    function automatic slot_act_e slot_action(input logic flush, input logic hold,
                                              input logic hold_prev);
        if (flush)
            return ACT_FLUSH;
        else if (hold)
            return ACT_HOLD;
        else if (hold_prev)
            return ACT_BUBBLE;
        return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_slot.sv
// One pipeline slot: flush beats hold, hold beats bubble, bubble beats advance.
module pipe_slot
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              hold_prev,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic [REG_AW-1:0] up_dest,
    input  logic              up_wen,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [REG_AW-1:0] dest,
    output logic              wen
);

    logic              valid_q, valid_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [REG_AW-1:0] dest_q, dest_d;

    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        data_d  = data_q;
        dest_d  = dest_q;
        case (slot_action(flush, hold, hold_prev))
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                wen_d   = 1'b0;
            end
            ACT_ADVANCE: begin
                valid_d = up_valid;
                wen_d   = up_wen;
                data_d  = up_data;
                dest_d  = up_dest;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
        end
    end

    // Payload is qualified by valid, so it needs no reset
    always_ff @(posedge CLOCK) begin
        data_q <= data_d;
        dest_q <= dest_d;
    end

    assign valid = valid_q;
    assign wen   = wen_q;
    assign data  = data_q;
    assign dest  = dest_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with back-propagating stall, per-slot flush,
// youngest-first result forwarding and a saturating stall-cycle counter.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int NSRC   = DEF_NSRC,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                             CLOCK,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [REG_AW-1:0]                in_dest,
    input  logic                             in_wen,
    output logic                             in_ready,
    input  logic [STAGES-1:0]                stall,
    input  logic [STAGES-1:0]                flush,
    output logic [STAGES-1:0]                stage_valid,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    output logic [REG_AW-1:0]                out_dest,
    output logic                             out_wen,
    input  logic [NSRC*REG_AW-1:0]           src_addr,
    output logic [NSRC-1:0]                  fwd_hit,
    output logic [NSRC*$clog2(STAGES)-1:0]   fwd_stage,
    output logic [NSRC*DATA_W-1:0]           fwd_data,
    output logic [CNT_W-1:0]                 stall_cnt
);

    localparam int SW = $clog2(STAGES);

    generate
        if (STAGES < 2 || NSRC < 1) begin : g_bad_params
            $error("pipe_stage_chain: requires STAGES>=2 and NSRC>=1");
        end
    endgenerate

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] slot_valid;
    logic [STAGES-1:0] slot_wen;
    logic [DATA_W-1:0] slot_data [STAGES];
    logic [REG_AW-1:0] slot_dest [STAGES];

    // A stall freezes its own slot and everything younger behind it
    assign hold[STAGES-1] = stall[STAGES-1];
    generate
        for (genvar gi = 0; gi < STAGES - 1; gi++) begin : g_hold
            assign hold[gi] = stall[gi] | hold[gi+1];
        end
    endgenerate

    assign in_ready = ~hold[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                pipe_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_slot (
                    .CLOCK    (CLOCK),
                    .rst      (rst),
                    .flush    (flush[0]),
                    .hold     (hold[0]),
                    .hold_prev(1'b0),
                    .up_valid (in_valid),
                    .up_data  (in_data),
                    .up_dest  (in_dest),
                    .up_wen   (in_wen),
                    .valid    (slot_valid[0]),
                    .data     (slot_data[0]),
                    .dest     (slot_dest[0]),
                    .wen      (slot_wen[0])
                );
            end else begin : g_body
                pipe_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_slot (
                    .CLOCK    (CLOCK),
                    .rst      (rst),
                    .flush    (flush[gi]),
                    .hold     (hold[gi]),
                    .hold_prev(hold[gi-1]),
                    .up_valid (slot_valid[gi-1]),
                    .up_data  (slot_data[gi-1]),
                    .up_dest  (slot_dest[gi-1]),
                    .up_wen   (slot_wen[gi-1]),
                    .valid    (slot_valid[gi]),
                    .data     (slot_data[gi]),
                    .dest     (slot_dest[gi]),
                    .wen      (slot_wen[gi])
                );
            end
        end
    endgenerate

    assign stage_valid = slot_valid;
    assign out_valid   = slot_valid[STAGES-1];
    assign out_data    = slot_data[STAGES-1];
    assign out_dest    = slot_dest[STAGES-1];
    assign out_wen     = slot_valid[STAGES-1] & slot_wen[STAGES-1];

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd
            logic [REG_AW-1:0] query;
            logic              hit_c;
            logic [SW-1:0]     stage_c;
            logic [DATA_W-1:0] data_c;

            assign query = src_addr[gi*REG_AW +: REG_AW];

            // Scan oldest to youngest so the youngest match overwrites
            always_comb begin
                hit_c   = 1'b0;
                stage_c = '0;
                data_c  = '0;
                for (int k = STAGES - 1; k >= 0; k--) begin
                    if (slot_valid[k] && slot_wen[k] && slot_dest[k] == query &&
                        query != REG_AW'(REG_ZERO)) begin
                        hit_c   = 1'b1;
                        stage_c = SW'(k);
                        data_c  = slot_data[k];
                    end
                end
            end

            assign fwd_hit[gi]               = hit_c;
            assign fwd_stage[gi*SW +: SW]     = stage_c;
            assign fwd_data[gi*DATA_W +: DATA_W] = data_c;
        end
    endgenerate

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!in_ready && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (!rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomised and directed bench for pipe_stage_chain against an array-based reference model.
module tb_pipe_stage_chain;

    localparam int STAGES = 4;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NSRC   = 2;
    localparam int CNT_W  = 4;
    localparam int SW     = $clog2(STAGES);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       CLOCK = 1'b0;
    logic                       rst = 1'b0;
    logic                       in_valid = 1'b0;
    logic [DATA_W-1:0]          in_data = '0;
    logic [REG_AW-1:0]          in_dest = '0;
    logic                       in_wen = 1'b0;
    logic                       in_ready;
    logic [STAGES-1:0]          stall = '0;
    logic [STAGES-1:0]          flush = '0;
    logic [STAGES-1:0]          stage_valid;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [REG_AW-1:0]          out_dest;
    logic                       out_wen;
    logic [NSRC*REG_AW-1:0]     src_addr = '0;
    logic [NSRC-1:0]            fwd_hit;
    logic [NSRC*SW-1:0]         fwd_stage;
    logic [NSRC*DATA_W-1:0]     fwd_data;
    logic [CNT_W-1:0]           stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic              m_valid [STAGES];
    logic [DATA_W-1:0] m_data  [STAGES];
    logic [REG_AW-1:0] m_dest  [STAGES];
    logic              m_wen   [STAGES];
    int                m_cnt;

    always #5 CLOCK = ~CLOCK;

    pipe_stage_chain #(
        .STAGES(STAGES), .DATA_W(DATA_W), .REG_AW(REG_AW), .NSRC(NSRC), .CNT_W(CNT_W)
    ) dut (
        .CLOCK      (CLOCK),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_wen     (in_wen),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .stage_valid(stage_valid),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_dest   (out_dest),
        .out_wen    (out_wen),
        .src_addr   (src_addr),
        .fwd_hit    (fwd_hit),
        .fwd_stage  (fwd_stage),
        .fwd_data   (fwd_data),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic held(input int k);
        return (stall >> k) != '0;
    endfunction

    task automatic model_step();
        logic              pv [STAGES];
        logic [DATA_W-1:0] pd [STAGES];
        logic [REG_AW-1:0] pa [STAGES];
        logic              pw [STAGES];
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                m_valid[k] = 1'b0;
                m_wen[k]   = 1'b0;
            end
            m_cnt = 0;
            return;
        end
        pv = m_valid; pd = m_data; pa = m_dest; pw = m_wen;
        for (int k = 0; k < STAGES; k++) begin
            if (flush[k]) begin
                m_valid[k] = 1'b0;
            end else if (held(k)) begin
                // contents stay
            end else if (k == 0) begin
                m_valid[0] = in_valid; m_data[0] = in_data;
                m_dest[0] = in_dest;   m_wen[0] = in_wen;
            end else if (held(k - 1)) begin
                m_valid[k] = 1'b0;
            end else begin
                m_valid[k] = pv[k-1]; m_data[k] = pd[k-1];
                m_dest[k]  = pa[k-1]; m_wen[k]  = pw[k-1];
            end
        end
        if (held(0) && m_cnt < CNT_MAX)
            m_cnt++;
    endtask

    task automatic check_all();
        logic [STAGES-1:0] ev;
        for (int k = 0; k < STAGES; k++)
            ev[k] = m_valid[k];
        chk("stage_valid", 64'(stage_valid), 64'(ev));
        chk("out_valid", 64'(out_valid), 64'(m_valid[STAGES-1]));
        chk("out_wen", 64'(out_wen), 64'(m_valid[STAGES-1] & m_wen[STAGES-1]));
        if (m_valid[STAGES-1]) begin
            chk("out_data", 64'(out_data), 64'(m_data[STAGES-1]));
            chk("out_dest", 64'(out_dest), 64'(m_dest[STAGES-1]));
        end
        chk("in_ready", 64'(in_ready), 64'(!held(0)));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        for (int i = 0; i < NSRC; i++) begin
            logic [REG_AW-1:0] q;
            logic              eh;
            int                es;
            logic [DATA_W-1:0] ed;
            q = src_addr[i*REG_AW +: REG_AW];
            eh = 1'b0; es = 0; ed = '0;
            for (int k = 0; k < STAGES; k++) begin
                if (!eh && q != 0 && m_valid[k] && m_wen[k] && m_dest[k] == q) begin
                    eh = 1'b1; es = k; ed = m_data[k];
                end
            end
            chk($sformatf("fwd_hit%0d", i), 64'(fwd_hit[i]), 64'(eh));
            chk($sformatf("fwd_stage%0d", i), 64'(fwd_stage[i*SW +: SW]), 64'(es));
            chk($sformatf("fwd_data%0d", i), 64'(fwd_data[i*DATA_W +: DATA_W]), 64'(ed));
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge CLOCK);
        model_step();
        #1;
    endtask

    task automatic push(input logic v, input logic [DATA_W-1:0] d,
                        input logic [REG_AW-1:0] a, input logic w);
        in_valid = v; in_data = d; in_dest = a; in_wen = w;
        tick();
    endtask

    task automatic build_fwd(input logic slot1_wen);
        push(1'b1, 32'hBB, 5'd5, 1'b1);
        push(1'b1, 32'h11, 5'd7, 1'b1);
        push(1'b1, 32'hAA, 5'd5, slot1_wen);
        push(1'b1, 32'h22, 5'd9, 1'b1);
        in_valid = 1'b0;
        stall = 4'b1000;
        src_addr = {5'd0, 5'd5};
        #1;
    endtask

    initial begin
        for (int k = 0; k < STAGES; k++) begin
            m_valid[k] = 1'b0; m_wen[k] = 1'b0; m_data[k] = '0; m_dest[k] = '0;
        end
        m_cnt = 0;

        // Reset for two cycles
        rst = 1'b0;
        @(posedge CLOCK); model_step(); #1;
        @(posedge CLOCK); model_step(); #1;
        rst = 1'b1;
        chk("reset_stage_valid", 64'(stage_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        check_all();

        // Streaming 1,2,3,...
        for (int n = 1; n <= 8; n++) begin
            push(1'b1, DATA_W'(n), REG_AW'(n), n[0]);
            if (n == 4)
                chk("first_out", 64'(out_data), 64'd1);
        end

        // Stall slot 2 for two cycles
        stall = 4'b0100;
        push(1'b1, 32'd9, 5'd9, 1'b1);
        push(1'b1, 32'd9, 5'd9, 1'b1);
        stall = '0;
        chk("stall_cnt_two", 64'(stall_cnt), 64'd2);
        for (int n = 9; n <= 14; n++)
            push(1'b1, DATA_W'(n), REG_AW'(n), 1'b1);

        // Flush beats stall
        flush = 4'b0011; stall = 4'b0010;
        push(1'b1, 32'd15, 5'd15, 1'b1);
        flush = '0; stall = '0;
        chk("flush_valid", 64'(stage_valid[1:0]), 64'd0);
        push(1'b0, 32'd0, 5'd0, 1'b0);
        push(1'b0, 32'd0, 5'd0, 1'b0);

        // Forwarding: youngest wins, zero register never hits
        build_fwd(1'b1);
        chk("fwd5_hit", 64'(fwd_hit[0]), 64'd1);
        chk("fwd5_stage", 64'(fwd_stage[SW-1:0]), 64'd1);
        chk("fwd5_data", 64'(fwd_data[DATA_W-1:0]), 64'hAA);
        chk("fwd0_hit", 64'(fwd_hit[1]), 64'd0);
        tick();
        stall = '0;
        build_fwd(1'b0);
        chk("fwd5_old_stage", 64'(fwd_stage[SW-1:0]), 64'd3);
        chk("fwd5_old_data", 64'(fwd_data[DATA_W-1:0]), 64'hBB);
        tick();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            stall = ($urandom_range(0, 3) == 0) ? STAGES'($urandom) : '0;
            flush = ($urandom_range(0, 5) == 0) ? STAGES'($urandom) : '0;
            src_addr = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
            rst = ($urandom_range(0, 60) != 0);
            push(1'($urandom), DATA_W'($urandom), REG_AW'($urandom_range(0, 7)), 1'($urandom));
        end
        rst = 1'b1; stall = '0; flush = '0;
        push(1'b0, 32'd0, 5'd0, 1'b0);

        // Saturation, then reset during a stall
        stall = 4'b0001;
        for (int n = 0; n < 20; n++)
            push(1'b1, DATA_W'(n), 5'd3, 1'b1);
        chk("stall_cnt_sat", 64'(stall_cnt), 64'(CNT_MAX));
        rst = 1'b0;
        push(1'b1, 32'd1, 5'd3, 1'b1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_stage_valid", 64'(stage_valid), 64'd0);
        rst = 1'b1; stall = '0;
        push(1'b0, 32'd0, 5'd0, 1'b0);
        #1;
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
